// File: rtl/aes_sbox_mask_rng.sv
// ---------------------------------------------------------------------------
// aes_sbox_mask_rng
//
// Fresh masking randomness source for a pipelined masked AES S-box. A bank
// of 32-bit Galois LFSR lanes is loaded one seed word per lane through a
// ready/valid handshake. The bank is warmed up by a fixed number of advances
// and then advanced once for every output the consumer takes.
//
// Ports:
//   ClkxCI        clock
//   RstxRI        asynchronous active-high reset
//   SeedxDI       seed word for the lane currently being loaded
//   SeedValidxSI  seed word valid
//   SeedReadyxSO  block accepts a seed word (IDLE / LOAD)
//   ReseedxSI     restart seeding from lane 0
//   EnxSI         consumer took the current outputs; advance (RUN only)
//   RandValidxSO  RandomZxDO / RandomBxDO hold usable randomness
//   RandomZxDO    S-box RandomZ masks    = C[Z_WIDTH-1:0]
//   RandomBxDO    S-box RandomB blinding = C[Z_WIDTH +: B_WIDTH]
//   ReseedReqxSO  output budget exhausted; sticky until reseed
// where C = {lane[NLANES-1], ..., lane[0]}.
// ---------------------------------------------------------------------------
module aes_sbox_mask_rng #(
    parameter int Z_WIDTH         = 36,
    parameter int B_WIDTH         = 36,
    parameter int STEPS_PER_CYCLE = 32,
    parameter int WARMUP_CYCLES   = 16,
    parameter int MAX_OUTPUTS     = 65535
) (
    input  logic               ClkxCI,
    input  logic               RstxRI,
    input  logic [31:0]        SeedxDI,
    input  logic               SeedValidxSI,
    output logic               SeedReadyxSO,
    input  logic               ReseedxSI,
    input  logic               EnxSI,
    output logic               RandValidxSO,
    output logic [Z_WIDTH-1:0] RandomZxDO,
    output logic [B_WIDTH-1:0] RandomBxDO,
    output logic               ReseedReqxSO
);

    localparam int NLANES = (Z_WIDTH + B_WIDTH + 31) / 32;
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    localparam logic [31:0]      POLY      = 32'h80200003;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NLANES - 1);
    localparam logic [7:0]       WARM_LAST = 8'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);
    localparam logic [23:0]      OUT_MAX   = 24'(MAX_OUTPUTS);

    typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] lane_idx;
    logic [7:0]       warm_cnt;
    logic [23:0]      out_cnt;

    logic             seed_fire;
    logic             advance;
    logic [31:0]      seed_word;

    logic [31:0]            lane [NLANES];
    logic [NLANES*32-1:0]   lane_concat;
    logic                   unused_concat_bits;

    // STEPS_PER_CYCLE Galois steps unrolled into one combinational cone.
    function automatic logic [31:0] lane_advance(input logic [31:0] s);
        logic [31:0] t;
        // NOTE: blocking assignments here build a combinational chain; each
        // step must see the result of the previous one within the same call.
        t = s;
        for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
            t = (t >> 1) ^ (t[0] ? POLY : 32'h0);
        end
        return t;
    endfunction

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_word = (SeedxDI == 32'h0) ? 32'h1 : SeedxDI;

    // ---------------------------------------------------------------- state
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RstxRI) begin
            state    <= IDLE;
            lane_idx <= '0;
            warm_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state <= state_next;
            if (ReseedxSI) begin
                lane_idx <= '0;
                warm_cnt <= '0;
                out_cnt  <= '0;
            end else begin
                if (seed_fire) begin
                    lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + IDX_W'(1);
                    warm_cnt <= '0;
                end
                if (state == WARMUP) begin
                    warm_cnt <= warm_cnt + 8'd1;
                end
                // Saturate so the budget flag stays up while RUN continues.
                if (state == RUN && EnxSI && out_cnt != OUT_MAX) begin
                    out_cnt <= out_cnt + 24'd1;
                end
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            IDLE, LOAD: begin
                if (seed_fire) begin
                    if (lane_idx == LAST_LANE) begin
                        state_next = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: state_next = RUN;
            default: state_next = IDLE;
        endcase
        // Reseed overrides everything, including a same-cycle handshake.
        if (ReseedxSI) begin
            state_next = LOAD;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        SeedReadyxSO = (state == IDLE) || (state == LOAD);
        RandValidxSO = (state == RUN);
        ReseedReqxSO = (out_cnt == OUT_MAX);
        seed_fire    = SeedValidxSI && SeedReadyxSO && !ReseedxSI;
        advance      = !ReseedxSI && ((state == WARMUP) || (state == RUN && EnxSI));
    end

    // ---------------------------------------------------------------- lanes
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        // NOTE: the lane bank is reset because its registers drive the
        // outputs directly and must read zero out of reset.
        always_ff @(posedge ClkxCI or posedge RstxRI) begin
            if (RstxRI) begin
                lane[g] <= '0;
            end else if (seed_fire && lane_idx == IDX_W'(g)) begin
                lane[g] <= seed_word;
            end else if (advance) begin
                lane[g] <= lane_advance(lane[g]);
            end
        end
    end

    always_comb begin
        lane_concat = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_concat[i*32 +: 32] = lane[i];
        end
    end

    assign RandomZxDO = lane_concat[Z_WIDTH-1:0];
    assign RandomBxDO = lane_concat[Z_WIDTH +: B_WIDTH];

    // Bits of the top lane above Z_WIDTH+B_WIDTH are intentionally dropped.
    assign unused_concat_bits = ^lane_concat;

endmodule

// File: tb/tb_aes_sbox_mask_rng.sv
// ---------------------------------------------------------------------------
// tb_aes_sbox_mask_rng
//
// Two instances share one clock:
//   dut_a : STEPS_PER_CYCLE=1, WARMUP_CYCLES=0, MAX_OUTPUTS=4 (single-step
//           values, stall, budget, reseed collision, zero seeds)
//   dut_b : STEPS_PER_CYCLE=32, WARMUP_CYCLES=16 (warm-up timing and values,
//           asynchronous reset mid-warm-up)
// ---------------------------------------------------------------------------
module tb_aes_sbox_mask_rng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // ------------------------------------------------------------- dut_a
    logic        a_rst, a_seed_valid, a_seed_ready, a_reseed, a_en, a_valid, a_req;
    logic [31:0] a_seed;
    logic [35:0] a_z, a_b;

    aes_sbox_mask_rng #(
        .Z_WIDTH(36), .B_WIDTH(36), .STEPS_PER_CYCLE(1),
        .WARMUP_CYCLES(0), .MAX_OUTPUTS(4)
    ) dut_a (
        .ClkxCI(clk), .RstxRI(a_rst),
        .SeedxDI(a_seed), .SeedValidxSI(a_seed_valid), .SeedReadyxSO(a_seed_ready),
        .ReseedxSI(a_reseed), .EnxSI(a_en), .RandValidxSO(a_valid),
        .RandomZxDO(a_z), .RandomBxDO(a_b), .ReseedReqxSO(a_req)
    );

    // ------------------------------------------------------------- dut_b
    logic        b_rst, b_seed_valid, b_seed_ready, b_reseed, b_en, b_valid, b_req;
    logic [31:0] b_seed;
    logic [35:0] b_z, b_b;

    aes_sbox_mask_rng #(
        .Z_WIDTH(36), .B_WIDTH(36), .STEPS_PER_CYCLE(32),
        .WARMUP_CYCLES(16), .MAX_OUTPUTS(65535)
    ) dut_b (
        .ClkxCI(clk), .RstxRI(b_rst),
        .SeedxDI(b_seed), .SeedValidxSI(b_seed_valid), .SeedReadyxSO(b_seed_ready),
        .ReseedxSI(b_reseed), .EnxSI(b_en), .RandValidxSO(b_valid),
        .RandomZxDO(b_z), .RandomBxDO(b_b), .ReseedReqxSO(b_req)
    );

    // ------------------------------------------------------------ helpers
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_a(input logic [31:0] w);
        a_seed       = w;
        a_seed_valid = 1'b1;
        tick();
        a_seed_valid = 1'b0;
    endtask

    task automatic seed_b(input logic [31:0] w);
        b_seed       = w;
        b_seed_valid = 1'b1;
        tick();
        b_seed_valid = 1'b0;
    endtask

    // Reference lane update: one step of s' = (s >> 1) ^ (s[0] ? poly : 0).
    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_advance32(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 32; k++) t = ref_step(t);
        return t;
    endfunction

    logic [31:0] m0, m1, m2;

    // Hard bound in case the sequence stalls for any reason.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1; a_seed = '0; a_seed_valid = 1'b0; a_reseed = 1'b0; a_en = 1'b0;
        b_rst = 1'b1; b_seed = '0; b_seed_valid = 1'b0; b_reseed = 1'b0; b_en = 1'b0;
        tick();
        tick();

        // ------------------------------------------------------ reset state
        check("a_rst_z",     a_z, 36'h0);
        check("a_rst_b",     a_b, 36'h0);
        check("a_rst_valid", a_valid, 1'b0);
        check("a_rst_req",   a_req, 1'b0);
        check("b_rst_z",     b_z, 36'h0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        check("a_idle_ready", a_seed_ready, 1'b1);

        // -------------------------------------- dut_a: seeds 1,2,3 -> RUN
        seed_a(32'h1);
        check("a_load_valid", a_valid, 1'b0);
        seed_a(32'h2);
        seed_a(32'h3);
        check("a_run_valid", a_valid, 1'b1);
        check("a_run_ready", a_seed_ready, 1'b0);
        check("a_run_z0",    a_z, 36'h2_00000001);   // {lane1[3:0], lane0}
        check("a_run_b0",    a_b, 36'h03_0000000);   // {lane2[7:0], lane1[31:4]}

        // ------------------------- EnxSI pattern 1,0,1,1,1,1, budget of 4
        a_en = 1'b1; tick();
        check("a_adv1_z", a_z, 36'h1_80200003);
        check("a_adv1_b", a_b, 36'h02_0000000);
        a_en = 1'b0; tick();
        check("a_stall_z",   a_z, 36'h1_80200003);
        check("a_stall_b",   a_b, 36'h02_0000000);
        check("a_stall_req", a_req, 1'b0);
        a_en = 1'b1; tick();
        check("a_adv2_z", a_z, 36'h3_C0300002);
        check("a_adv2_b", a_b, 36'h01_8020000);
        tick();
        check("a_adv3_z0", a_z[31:0], 32'h60180001);
        check("a_adv3_req", a_req, 1'b0);
        tick();
        check("a_adv4_z0",    a_z[31:0], 32'hB02C0003);
        check("a_adv4_req",   a_req, 1'b1);
        check("a_adv4_valid", a_valid, 1'b1);
        tick();
        check("a_adv5_z0",    a_z[31:0], 32'hD8360002);
        check("a_adv5_req",   a_req, 1'b1);
        check("a_adv5_valid", a_valid, 1'b1);
        a_en = 1'b0;

        // ------------------------- reseed collides with a seed handshake
        a_reseed = 1'b1; a_seed = 32'hDEADBEEF; a_seed_valid = 1'b1; a_en = 1'b1;
        tick();
        a_reseed = 1'b0; a_seed_valid = 1'b0;
        check("a_rs_valid", a_valid, 1'b0);
        check("a_rs_req",   a_req, 1'b0);
        check("a_rs_ready", a_seed_ready, 1'b1);
        check("a_rs_z0",    a_z[31:0], 32'hD8360002);
        // EnxSI held high in LOAD must not advance the lanes.
        tick();
        check("a_load_en_z0", a_z[31:0], 32'hD8360002);
        a_en = 1'b0;

        // ------------------------- zero seeds land in lanes 0,1,2 as 1
        seed_a(32'h0);
        check("a_zs_lane0", a_z[31:0], 32'h00000001);
        seed_a(32'h0);
        seed_a(32'h0);
        check("a_zs_valid", a_valid, 1'b1);
        check("a_zs_req",   a_req, 1'b0);
        check("a_zs_z",     a_z, 36'h1_00000001);
        check("a_zs_b",     a_b, 36'h01_0000000);

        // ------------------------------------- dut_b: warm-up of 16
        m0 = 32'h12345678; m1 = 32'h9ABCDEF0; m2 = 32'h0F1E2D3C;
        seed_b(m0);
        seed_b(m1);
        seed_b(m2);
        check("b_warm_valid0", b_valid, 1'b0);
        check("b_warm_ready",  b_seed_ready, 1'b0);
        b_en = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("b_warm_valid%0d", k), b_valid, (k == 16));
        end
        for (int k = 0; k < 16; k++) begin
            m0 = ref_advance32(m0);
            m1 = ref_advance32(m1);
            m2 = ref_advance32(m2);
        end
        check("b_warm_z", b_z, {m1[3:0], m0});
        check("b_warm_b", b_b, {m2[7:0], m1[31:4]});
        check("b_warm_req", b_req, 1'b0);

        // ----------------------- reseed, then reset in the middle of warm-up
        b_reseed = 1'b1; tick(); b_reseed = 1'b0;
        check("b_rs_valid", b_valid, 1'b0);
        check("b_rs_ready", b_seed_ready, 1'b1);
        m0 = 32'hCAFEF00D; m1 = 32'h0BADC0DE; m2 = 32'h55AA33CC;
        seed_b(m0);
        seed_b(m1);
        seed_b(m2);
        repeat (5) tick();
        for (int k = 0; k < 5; k++) begin
            m0 = ref_advance32(m0);
            m1 = ref_advance32(m1);
        end
        check("b_mid_z", b_z, {m1[3:0], m0});
        check("b_mid_valid", b_valid, 1'b0);
        #2;
        b_rst = 1'b1;
        #1;
        check("b_arst_z",     b_z, 36'h0);
        check("b_arst_b",     b_b, 36'h0);
        check("b_arst_valid", b_valid, 1'b0);
        check("b_arst_req",   b_req, 1'b0);
        tick();
        b_rst = 1'b0;
        repeat (20) tick();
        check("b_post_ready", b_seed_ready, 1'b1);
        check("b_post_valid", b_valid, 1'b0);
        check("b_post_z",     b_z, 36'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_sbox_mask_rng.md
Name: aes_sbox_mask_rng

Overview:
- Supplies the fresh masking randomness that the pipelined masked AES S-box consumes every cycle: the multiplication masks (RandomZ) and the blinding bits (RandomB).
- It drives the producer side of the S-box randomness interface.
- It holds a bank of 32-bit Galois LFSR lanes, loaded through a seed handshake. The bank is warmed up, then advanced once per consumed output.
- It sits between the system TRNG/seed source and one or more masked S-box instances.

Parameters:
- Z_WIDTH, 36, width of RandomZxDO. Must equal the S-box RandomZ width for the chosen SHARES.
- B_WIDTH, 36, width of RandomBxDO. Must equal the S-box RandomB width.
- STEPS_PER_CYCLE, 32, LFSR steps applied to every lane per advance, unrolled combinationally. Range 1..32.
- WARMUP_CYCLES, 16, number of advances discarded after seeding. Range 0..255.
- MAX_OUTPUTS, 65535, advances in RUN after which ReseedReqxSO asserts. Range 1..2^24-1.
- Derived (not settable): NLANES = ceil((Z_WIDTH+B_WIDTH)/32).

Ports:
- ClkxCI  in  1  clock.
- RstxRI  in  1  reset, asynchronous, active-high.
- SeedxDI  in  32  seed word for the current lane.
- SeedValidxSI  in  1  seed word valid.
- SeedReadyxSO  out  1  block accepts a seed word.
- ReseedxSI  in  1  request to restart seeding.
- EnxSI  in  1  consumer took the current outputs; advance.
- RandValidxSO  out  1  RandomZxDO/RandomBxDO hold fresh, usable randomness.
- RandomZxDO  out  Z_WIDTH  masks for the S-box RandomZ input.
- RandomBxDO  out  B_WIDTH  blinding bits for the S-box RandomB input.
- ReseedReqxSO  out  1  output budget exhausted; reseed advised.

Behaviour:
- Lane step: s' = (s >> 1) ^ (s[0] ? 32'h80200003 : 0). One advance applies STEPS_PER_CYCLE steps to every lane in parallel.
- Output mapping:
  - Concatenation C = {lane[NLANES-1], ..., lane[0]}, with lane0 at the LSBs.
  - RandomZxDO = C[Z_WIDTH-1:0].
  - RandomBxDO = C[Z_WIDTH +: B_WIDTH].
  - Outputs are the lane registers directly, so there is no extra output latency. Unused top bits are ignored.
- Reset (asynchronous): all lanes 0, lane index 0, counters 0, state IDLE, RandValidxSO=0, ReseedReqxSO=0. RandomZxDO/RandomBxDO read 0.
- FSM states: IDLE, LOAD, WARMUP, RUN.
  - IDLE: SeedReadyxSO=1. The first SeedValidxSI&&SeedReadyxSO writes lane0. The FSM then goes to LOAD with index 1, or to WARMUP/RUN if NLANES=1.
  - LOAD: SeedReadyxSO=1. Each handshake writes lane[index] and increments the index. The handshake that writes lane NLANES-1 goes to WARMUP, or to RUN if WARMUP_CYCLES=0.
  - WARMUP: advance every cycle, independent of EnxSI; count advances. After WARMUP_CYCLES advances, enter RUN. RandValidxSO is 1 from the first RUN cycle.
  - RUN: RandValidxSO=1. On each EnxSI=1 edge, advance once and increment the output counter. EnxSI=0 holds the outputs stable.
- Seed word of 0: written as 32'h00000001 to avoid LFSR lock-up.
- SeedReadyxSO=0 in WARMUP and RUN.
- Output budget: ReseedReqxSO is set when the output counter reaches MAX_OUTPUTS. It is sticky until reseed. RUN continues, and the counter saturates.
- ReseedxSI (any state, sampled at the clock edge):
  - Effect: next state LOAD with index 0; RandValidxSO=0 on the following cycle; output counter and ReseedReqxSO cleared; lanes keep their values until overwritten.
  - Priority: ReseedxSI has priority over EnxSI and over a simultaneous seed handshake; that seed word is dropped and SeedReadyxSO holds 1.
- EnxSI outside RUN is ignored.
- Reset asserted mid-LOAD or mid-WARMUP: immediate return to the reset values; a full reseed is required.

Test Plan:
- STEPS_PER_CYCLE=1, WARMUP_CYCLES=0, Z=B=36 (NLANES=3):
  - Stimulus: seeds 1, 2, 3.
  - Next cycle: RandValidxSO=1, lane0=0x00000001.
  - After EnxSI: lane0=0x80200003.
  - After a second EnxSI: lane0=0xC0300002.
  - Check RandomZxDO[31:0] and RandomZxDO[35:32] = lane1[3:0].
- Zero seed: seeds 0, 0, 0 -> each lane reads 0x00000001 on entering RUN; outputs are never all-zero.
- Warm-up:
  - Stimulus: WARMUP_CYCLES=16, EnxSI=0 throughout.
  - RandValidxSO stays 0 for exactly 16 cycles after the last seed handshake, then goes 1.
  - Lane values equal the reference model after 16 advances.
- Stall and budget:
  - Stimulus: MAX_OUTPUTS=4 in RUN, EnxSI pattern 1,0,1,1,1,1.
  - Outputs hold during the 0 cycle.
  - ReseedReqxSO rises after the 4th advance and stays 1.
  - RandValidxSO stays 1.
- Reseed collision:
  - Stimulus: ReseedxSI and SeedValidxSI in the same RUN cycle.
  - Next state LOAD with index 0; the simultaneous seed word is not written.
  - RandValidxSO=0 and ReseedReqxSO=0 next cycle.
- Reset mid-WARMUP: assert RstxRI asynchronously -> all outputs 0 within the same cycle, state IDLE, SeedReadyxSO=1 after release.
